// File: rtl/sram_controller.sv
// sram_controller
//   Sequencing FSM for the ANN's shared SRAM loader. A detect request starts
//   one image load. After that the block serves any number of coefficient
//   loads on request, until the ANN reports that processing is done. It then
//   returns to idle.
//
// Ports
//   clk                  in  system clock, rising edge
//   n_rst                in  asynchronous reset, ACTIVE-HIGH despite the name
//   start_detecting      in  pulse/level: begin a detection run (image load)
//   request_coef         in  pulse/level: fetch the next coefficient block
//   done_processing      in  level: ANN finished, end the run
//   sram_done            in  pulse from the SRAM engine: current load complete
//   image_weights_loaded out 1 while image data is resident (COEF_* states)
//   n_coef_image         out load select: 0 = image, 1 = coefficients
//   start_sram           out one-cycle start pulse to the SRAM engine
//
// This is a Moore machine. Every output is decoded from the registered state
// only. A reset therefore drives the outputs low as soon as the state register
// clears, without waiting for a clock edge.

module sram_controller (
    input  logic clk,
    input  logic n_rst,
    input  logic start_detecting,
    input  logic request_coef,
    input  logic done_processing,
    input  logic sram_done,
    output logic image_weights_loaded,
    output logic n_coef_image,
    output logic start_sram
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        IMG_START  = 3'd1,
        IMG_WAIT   = 3'd2,
        COEF_IDLE  = 3'd3,
        COEF_START = 3'd4,
        COEF_WAIT  = 3'd5
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic. Each state reacts only to the inputs it cares about.
    // Every other input is ignored. done_processing is seen only in
    // COEF_IDLE, so a done that arrives during a load takes effect once that
    // load has finished.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (start_detecting) state_d = IMG_START;
            IMG_START:  state_d = IMG_WAIT;
            IMG_WAIT:   if (sram_done) state_d = COEF_IDLE;
            COEF_IDLE: begin
                if (done_processing)   state_d = IDLE;
                else if (request_coef) state_d = COEF_START;
            end
            COEF_START: state_d = COEF_WAIT;
            COEF_WAIT:  if (sram_done) state_d = COEF_IDLE;
            default:    state_d = IDLE;   // encodings 6/7 recover
        endcase
    end

    // Output decode from state only.
    always_comb begin
        start_sram           = 1'b0;
        n_coef_image         = 1'b0;
        image_weights_loaded = 1'b0;
        unique case (state_q)
            IMG_START: start_sram = 1'b1;
            COEF_IDLE: begin
                n_coef_image         = 1'b1;
                image_weights_loaded = 1'b1;
            end
            COEF_START: begin
                start_sram           = 1'b1;
                n_coef_image         = 1'b1;
                image_weights_loaded = 1'b1;
            end
            COEF_WAIT: begin
                n_coef_image         = 1'b1;
                image_weights_loaded = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    logic clk = 1'b0;
    logic n_rst;
    logic start_detecting, request_coef, done_processing, sram_done;
    logic image_weights_loaded, n_coef_image, start_sram;

    int tests  = 0;
    int errors = 0;

    // Expected {start_sram, n_coef_image, image_weights_loaded} after each edge
    logic [2:0] exp_q [$];
    int         step_id [$];
    int         nstep = 0;

    sram_controller dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .start_detecting     (start_detecting),
        .request_coef        (request_coef),
        .done_processing     (done_processing),
        .sram_done           (sram_done),
        .image_weights_loaded(image_weights_loaded),
        .n_coef_image        (n_coef_image),
        .start_sram          (start_sram)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the outputs
    // expected once the next rising edge has been taken.
    task automatic step(input logic sd, input logic rc, input logic dp,
                        input logic done, input logic [2:0] exp);
        @(negedge clk);
        start_detecting = sd;
        request_coef    = rc;
        done_processing = dp;
        sram_done       = done;
        exp_q.push_back(exp);
        step_id.push_back(nstep);
        nstep++;
    endtask

    // Scoreboard: pop one expectation per rising edge, sampled 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            automatic logic [2:0] e = exp_q.pop_front();
            automatic int id = step_id.pop_front();
            chk($sformatf("step%0d {ss,nc,iwl}", id),
                {29'd0, start_sram, n_coef_image, image_weights_loaded}, {29'd0, e});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b1;
        start_detecting = 0; request_coef = 0; done_processing = 0; sram_done = 0;
        #1;
        chk("reset_ss",  start_sram, 0);
        chk("reset_nc",  n_coef_image, 0);
        chk("reset_iwl", image_weights_loaded, 0);

        // Hold reset for 5 cycles with the inputs at 0. Nothing may pulse.
        repeat (5) step(0, 0, 0, 0, 3'b000);
        @(negedge clk); n_rst = 1'b0;
        repeat (2) step(0, 0, 0, 0, 3'b000);
        // In IDLE, every input except start_detecting is ignored.
        step(0, 1, 0, 0, 3'b000);
        step(0, 0, 1, 0, 3'b000);
        step(0, 0, 0, 1, 3'b000);

        // Image load.
        step(1, 0, 0, 0, 3'b100);   // IMG_START
        step(0, 0, 0, 0, 3'b000);   // IMG_WAIT
        repeat (5) step(0, 0, 0, 0, 3'b000);
        step(0, 1, 0, 0, 3'b000);   // request_coef ignored in IMG_WAIT
        step(0, 0, 1, 0, 3'b000);   // done_processing ignored in IMG_WAIT
        step(1, 0, 0, 0, 3'b000);   // start_detecting ignored in IMG_WAIT
        step(0, 0, 0, 1, 3'b011);   // sram_done -> COEF_IDLE
        step(0, 0, 0, 1, 3'b011);   // stale done in COEF_IDLE ignored

        // Two coefficient loads.
        repeat (2) begin
            step(0, 1, 0, 0, 3'b111);   // COEF_START
            step(0, 0, 0, 0, 3'b011);   // COEF_WAIT
            repeat (5) step(0, 0, 0, 0, 3'b011);
            step(0, 0, 0, 1, 3'b011);   // back to COEF_IDLE
            step(0, 0, 0, 0, 3'b011);
        end

        // A done_processing that arrives during a load waits for the load to finish.
        step(0, 1, 0, 0, 3'b111);
        step(0, 0, 1, 0, 3'b011);
        step(0, 0, 1, 0, 3'b011);
        step(0, 0, 1, 1, 3'b011);   // COEF_IDLE
        step(0, 1, 1, 0, 3'b000);   // done wins over request -> IDLE

        // New run; a level-held request_coef retriggers after the load completes.
        step(1, 0, 0, 0, 3'b100);
        step(0, 0, 0, 0, 3'b000);
        step(0, 0, 0, 1, 3'b011);
        step(0, 1, 0, 0, 3'b111);
        step(0, 1, 0, 0, 3'b011);   // COEF_WAIT, request ignored
        step(0, 1, 0, 1, 3'b011);   // COEF_IDLE
        step(0, 1, 0, 0, 3'b111);   // retriggered
        step(0, 0, 0, 0, 3'b011);   // COEF_WAIT

        // Asynchronous reset in the middle of COEF_WAIT.
        @(posedge clk); #3;
        chk("pre_async_iwl", image_weights_loaded, 1);
        n_rst = 1'b1;
        #1;
        chk("async_ss",  start_sram, 0);
        chk("async_nc",  n_coef_image, 0);
        chk("async_iwl", image_weights_loaded, 0);
        step(0, 0, 0, 1, 3'b000);
        @(negedge clk); n_rst = 1'b0;
        step(0, 0, 0, 1, 3'b000);   // stale sram_done ignored
        step(0, 1, 0, 0, 3'b000);
        step(0, 0, 1, 0, 3'b000);
        step(1, 0, 0, 0, 3'b100);   // still able to start
        step(0, 0, 0, 0, 3'b000);

        @(posedge clk); #2;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
